// File: rtl/hash_clk_throttle.sv
// ============================================================================
//  Module   : hash_clk_throttle
//  Purpose  : Duty-cycled clock enable for the hash cores, with a start-up
//             hold-off, a soft-start ramp and an immediate halt.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_clk_throttle #(
  parameter int HOLDOFF   = 1024,
  parameter int RAMP_STEP = 256,
  parameter int DUTY_BITS = 4
) (
  input  logic                 hash_clk,
  input  logic                 reset,
  input  logic [DUTY_BITS:0]   target_duty,
  input  logic                 target_load,
  input  logic                 halt,
  output logic                 core_ena,
  output logic [DUTY_BITS:0]   cur_duty,
  output logic [1:0]           state,
  output logic                 ramp_done
);

  localparam int c_tmax = (HOLDOFF > RAMP_STEP) ? HOLDOFF : RAMP_STEP;
  localparam int c_tw   = (c_tmax > 1) ? $clog2(c_tmax) : 1;

  localparam logic [c_tw-1:0]    c_hold_last = c_tw'(HOLDOFF - 1);
  localparam logic [c_tw-1:0]    c_step_last = c_tw'(RAMP_STEP - 1);
  localparam logic [DUTY_BITS:0] c_full      = {1'b1, {DUTY_BITS{1'b0}}};

  localparam logic [1:0] c_st_hold = 2'd0;
  localparam logic [1:0] c_st_ramp = 2'd1;
  localparam logic [1:0] c_st_run  = 2'd2;
  localparam logic [1:0] c_st_halt = 2'd3;

  logic [DUTY_BITS-1:0] r_phase;
  logic [c_tw-1:0]      r_timer;
  logic [DUTY_BITS:0]   r_target;
  logic [DUTY_BITS:0]   r_cur_duty;
  logic [1:0]           r_state;
  logic                 r_core_ena;

  logic [DUTY_BITS:0]   w_target_in;
  logic [DUTY_BITS:0]   w_phase_ext;

  assign w_target_in = (target_duty > c_full) ? c_full : target_duty;
  assign w_phase_ext = {1'b0, r_phase};

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      r_phase    <= '0;
      r_timer    <= '0;
      r_target   <= c_full;
      r_cur_duty <= '0;
      r_state    <= c_st_hold;
      r_core_ena <= 1'b0;
    end else begin
      r_phase    <= r_phase + 1'b1;
      // Live halt input gates the enable so cores stop one cycle after halt.
      r_core_ena <= (r_state != c_st_halt) && !halt && (w_phase_ext < r_cur_duty);

      if (target_load) begin
        r_target <= w_target_in;
      end

      if (halt) begin
        r_state    <= c_st_halt;
        r_cur_duty <= '0;
        r_timer    <= '0;
      end else begin
        case (r_state)
          c_st_hold: begin
            if (r_timer == c_hold_last) begin
              r_timer <= '0;
              r_state <= c_st_ramp;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          c_st_ramp: begin
            // Decreases apply at once; only increases are paced by the timer.
            if (r_cur_duty > r_target) begin
              r_cur_duty <= r_target;
            end else if (r_cur_duty == r_target) begin
              r_state <= c_st_run;
              r_timer <= '0;
            end else if (r_timer == c_step_last) begin
              r_timer    <= '0;
              r_cur_duty <= r_cur_duty + 1'b1;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          c_st_run: begin
            if (r_target > r_cur_duty) begin
              r_state <= c_st_ramp;
              r_timer <= '0;
            end else if (r_target < r_cur_duty) begin
              r_cur_duty <= r_target;
            end
          end
          default: begin
            // Leaving halt restarts the soft-start from zero, skipping hold-off.
            r_state    <= c_st_ramp;
            r_timer    <= '0;
            r_cur_duty <= '0;
          end
        endcase
      end
    end
  end

  assign core_ena  = r_core_ena;
  assign cur_duty  = r_cur_duty;
  assign state     = r_state;
  assign ramp_done = (r_state == c_st_run);

endmodule

`default_nettype wire

// File: tb/tb_hash_clk_throttle.sv
// ============================================================================
//  Module   : tb_hash_clk_throttle
//  Purpose  : Scoreboard bench for hash_clk_throttle (HOLDOFF=8, RAMP_STEP=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hash_clk_throttle;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic       hash_clk;
  logic       reset;
  logic [4:0] target_duty;
  logic       target_load;
  logic       halt;
  logic       core_ena;
  logic [4:0] cur_duty;
  logic [1:0] state;
  logic       ramp_done;

  int n_compared = 0;
  int n_mismatch = 0;

  typedef struct {
    int         n;
    logic       ld;
    logic [4:0] td;
    logic       hl;
    logic [4:0] cur;
    logic [1:0] st;
    logic       ena;
  } exp_t;

  exp_t       q[$];
  int         push_n;
  logic [4:0] prev_cur;
  logic [1:0] prev_st;

  hash_clk_throttle #(
    .HOLDOFF   (8),
    .RAMP_STEP (4),
    .DUTY_BITS (4)
  ) dut (
    .hash_clk    (hash_clk),
    .reset       (reset),
    .target_duty (target_duty),
    .target_load (target_load),
    .halt        (halt),
    .core_ena    (core_ena),
    .cur_duty    (cur_duty),
    .state       (state),
    .ramp_done   (ramp_done)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  // Expected duty of a ramp that entered RAMP at cycle 'start' from 'from'.
  function automatic logic [4:0] ramp_cur(int n, int start, int from, int to);
    int v;
    v = (n < start) ? from : from + (n - start) / 4;
    if (v > to) v = to;
    return 5'(v);
  endfunction

  function automatic logic [1:0] ramp_st(int n, int start, int from, int to);
    if (n < start) return ST_HOLD;
    if (n <= start + 4 * (to - from)) return ST_RAMP;
    return ST_RUN;
  endfunction

  // Queue one cycle of stimulus together with the state expected after that edge.
  task automatic push_cyc(input logic ld, input logic [4:0] td, input logic hl,
                          input logic [4:0] cur, input logic [1:0] st);
    exp_t e;
    e.n   = push_n;
    e.ld  = ld;
    e.td  = td;
    e.hl  = hl;
    e.cur = cur;
    e.st  = st;
    e.ena = (prev_st != ST_HALT) && !hl && (((push_n - 1) % 16) < int'(prev_cur));
    q.push_back(e);
    prev_cur = cur;
    prev_st  = st;
    push_n++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    target_load = 1'b0;
    target_duty = 5'd0;
    halt        = 1'b0;
    @(negedge hash_clk);
    reset    = 1'b0;
    push_n   = 1;
    prev_cur = 5'd0;
    prev_st  = ST_HOLD;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    halt        = 1'b1;
    target_load = 1'b1;
    target_duty = 5'd3;
    repeat (3) @(negedge hash_clk);
    n_compared++;
    if (core_ena !== 1'b0) begin
      n_mismatch++; $display("FAIL reset_core_ena got %b exp 0", core_ena);
    end
    n_compared++;
    if (cur_duty !== 5'd0) begin
      n_mismatch++; $display("FAIL reset_cur_duty got %0d exp 0", cur_duty);
    end
    n_compared++;
    if (state !== ST_HOLD) begin
      n_mismatch++; $display("FAIL reset_state got %0d exp 0", state);
    end
    n_compared++;
    if (ramp_done !== 1'b0) begin
      n_mismatch++; $display("FAIL reset_ramp_done got %b exp 0", ramp_done);
    end
    halt        = 1'b0;
    target_load = 1'b0;
  endtask

  task automatic test_no_load();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 80; n++)
      push_cyc(1'b0, 5'd0, 1'b0, ramp_cur(n, 8, 0, 16), ramp_st(n, 8, 0, 16));
    while (q.size() > 0) begin
      e = q.pop_front();
      target_load = e.ld; target_duty = e.td; halt = e.hl;
      @(negedge hash_clk);
      n_compared++;
      if ({core_ena, cur_duty, state, ramp_done} !== {e.ena, e.cur, e.st, e.st == ST_RUN}) begin
        n_mismatch++;
        $display("FAIL no_load cyc %0d ena/duty/state/done got %b/%0d/%0d/%b exp %b/%0d/%0d/%b",
                 e.n, core_ena, cur_duty, state, ramp_done, e.ena, e.cur, e.st, e.st == ST_RUN);
      end
    end
    target_load = 1'b0;
  endtask

  task automatic test_clamp_lower();
    exp_t e;
    push_cyc(1'b1, 5'd20, 1'b0, 5'd16, ST_RUN);
    for (int i = 0; i < 3; i++) push_cyc(1'b0, 5'd0, 1'b0, 5'd16, ST_RUN);
    push_cyc(1'b1, 5'd6, 1'b0, 5'd16, ST_RUN);
    for (int i = 0; i < 20; i++) push_cyc(1'b0, 5'd0, 1'b0, 5'd6, ST_RUN);
    while (q.size() > 0) begin
      e = q.pop_front();
      target_load = e.ld; target_duty = e.td; halt = e.hl;
      @(negedge hash_clk);
      n_compared++;
      if ({core_ena, cur_duty, state, ramp_done} !== {e.ena, e.cur, e.st, e.st == ST_RUN}) begin
        n_mismatch++;
        $display("FAIL clamp_lower cyc %0d ena/duty/state/done got %b/%0d/%0d/%b exp %b/%0d/%0d/%b",
                 e.n, core_ena, cur_duty, state, ramp_done, e.ena, e.cur, e.st, e.st == ST_RUN);
      end
    end
    target_load = 1'b0;
  endtask

  task automatic test_load_hold();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 60; n++)
      push_cyc(n == 1, 5'd4, 1'b0, ramp_cur(n, 8, 0, 4), ramp_st(n, 8, 0, 4));
    while (q.size() > 0) begin
      e = q.pop_front();
      target_load = e.ld; target_duty = e.td; halt = e.hl;
      @(negedge hash_clk);
      n_compared++;
      if ({core_ena, cur_duty, state, ramp_done} !== {e.ena, e.cur, e.st, e.st == ST_RUN}) begin
        n_mismatch++;
        $display("FAIL load_hold cyc %0d ena/duty/state/done got %b/%0d/%0d/%b exp %b/%0d/%0d/%b",
                 e.n, core_ena, cur_duty, state, ramp_done, e.ena, e.cur, e.st, e.st == ST_RUN);
      end
    end
    target_load = 1'b0;
  endtask

  task automatic test_raise();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 44; n++)
      push_cyc(n == 1, 5'd8, 1'b0, ramp_cur(n, 8, 0, 8), ramp_st(n, 8, 0, 8));
    push_cyc(1'b1, 5'd12, 1'b0, 5'd8, ST_RUN);
    for (int n = 46; n <= 70; n++)
      push_cyc(1'b0, 5'd0, 1'b0, ramp_cur(n, 46, 8, 12), ramp_st(n, 46, 8, 12));
    while (q.size() > 0) begin
      e = q.pop_front();
      target_load = e.ld; target_duty = e.td; halt = e.hl;
      @(negedge hash_clk);
      n_compared++;
      if ({core_ena, cur_duty, state, ramp_done} !== {e.ena, e.cur, e.st, e.st == ST_RUN}) begin
        n_mismatch++;
        $display("FAIL raise cyc %0d ena/duty/state/done got %b/%0d/%0d/%b exp %b/%0d/%0d/%b",
                 e.n, core_ena, cur_duty, state, ramp_done, e.ena, e.cur, e.st, e.st == ST_RUN);
      end
    end
    target_load = 1'b0;
  endtask

  // Continues from test_raise (RUN at 12, cycle 70); halt coincides with a load of 10.
  task automatic test_halt();
    exp_t e;
    push_cyc(1'b1, 5'd10, 1'b1, 5'd0, ST_HALT);
    for (int n = 72; n <= 80; n++) push_cyc(1'b0, 5'd0, 1'b1, 5'd0, ST_HALT);
    for (int n = 81; n <= 126; n++)
      push_cyc(1'b0, 5'd0, 1'b0, ramp_cur(n, 81, 0, 10), ramp_st(n, 81, 0, 10));
    while (q.size() > 0) begin
      e = q.pop_front();
      target_load = e.ld; target_duty = e.td; halt = e.hl;
      @(negedge hash_clk);
      n_compared++;
      if ({core_ena, cur_duty, state, ramp_done} !== {e.ena, e.cur, e.st, e.st == ST_RUN}) begin
        n_mismatch++;
        $display("FAIL halt cyc %0d ena/duty/state/done got %b/%0d/%0d/%b exp %b/%0d/%0d/%b",
                 e.n, core_ena, cur_duty, state, ramp_done, e.ena, e.cur, e.st, e.st == ST_RUN);
      end
    end
    target_load = 1'b0;
    halt        = 1'b0;
  endtask

  task automatic test_zero_target();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 30; n++)
      push_cyc(n == 1, 5'd0, 1'b0, 5'd0, ramp_st(n, 8, 0, 0));
    while (q.size() > 0) begin
      e = q.pop_front();
      target_load = e.ld; target_duty = e.td; halt = e.hl;
      @(negedge hash_clk);
      n_compared++;
      if ({core_ena, cur_duty, state, ramp_done} !== {e.ena, e.cur, e.st, e.st == ST_RUN}) begin
        n_mismatch++;
        $display("FAIL zero_target cyc %0d ena/duty/state/done got %b/%0d/%0d/%b exp %b/%0d/%0d/%b",
                 e.n, core_ena, cur_duty, state, ramp_done, e.ena, e.cur, e.st, e.st == ST_RUN);
      end
    end
    target_load = 1'b0;
  endtask

  task automatic test_reset_mid_ramp();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 30; n++)
      push_cyc(n == 1, 5'd6, 1'b0, ramp_cur(n, 8, 0, 6), ramp_st(n, 8, 0, 6));
    // After the pre-reset segment, a second segment checks the full restart.
    for (int pass = 0; pass < 2; pass++) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        target_load = e.ld; target_duty = e.td; halt = e.hl;
        @(negedge hash_clk);
        n_compared++;
        if ({core_ena, cur_duty, state, ramp_done} !== {e.ena, e.cur, e.st, e.st == ST_RUN}) begin
          n_mismatch++;
          $display("FAIL reset_mid pass %0d cyc %0d ena/duty/state/done got %b/%0d/%0d/%b exp %b/%0d/%0d/%b",
                   pass, e.n, core_ena, cur_duty, state, ramp_done, e.ena, e.cur, e.st, e.st == ST_RUN);
        end
      end
      target_load = 1'b0;
      if (pass == 0) begin
        reset = 1'b1;
        @(negedge hash_clk);
        reset = 1'b0;
        n_compared++;
        if ({core_ena, cur_duty, state} !== {1'b0, 5'd0, ST_HOLD}) begin
          n_mismatch++;
          $display("FAIL reset_mid_clear ena/duty/state got %b/%0d/%0d exp 0/0/0",
                   core_ena, cur_duty, state);
        end
        push_n   = 1;
        prev_cur = 5'd0;
        prev_st  = ST_HOLD;
        // Target must be back at full rate, so the ramp runs to 16.
        for (int n = 1; n <= 80; n++)
          push_cyc(1'b0, 5'd0, 1'b0, ramp_cur(n, 8, 0, 16), ramp_st(n, 8, 0, 16));
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    target_duty = 5'd0;
    target_load = 1'b0;
    halt        = 1'b0;
    test_reset();
    test_no_load();
    test_clamp_lower();
    test_load_hold();
    test_raise();
    test_halt();
    test_zero_target();
    test_reset_mid_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
